// File: rtl/rect_painter.sv
// rtl/rect_painter.sv - draws one red and one blue pseudo-random rectangle on white, committing new geometry only at frame boundaries
//
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   sec             one-cycle pulse per second; requests new geometry
//   frame_start     one-cycle pulse ahead of each frame; commit point
//   hcnt, vcnt      current pixel column / line
//   video_on        high while (hcnt, vcnt) is visible
//   red/green/blue  registered 2-bit colour levels (1 cycle after hcnt/vcnt/video_on)
//   busy            high while new geometry is pending (GEN or WAIT)
module rect_painter #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MIN_SIZE  = 32,
  parameter int          V_ACTIVE  = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec,
  input  logic       frame_start,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic       video_on,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic        gen, commit;
  logic [15:0] lfsr;

  // Geometry slots, in order: x0_r, y0_r, w_r, h_r, x0_b, y0_b, w_b, h_b.
  logic [8:0]  shadow [8];
  logic [8:0]  act    [8];

  logic [8:0]  l9, y_fold, size, sample;
  logic        in_r, in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    gen     = 1'b0;
    commit  = 1'b0;
    case (state)
      S_IDLE: begin
        // frame_start in this cycle is deliberately ignored: nothing is pending yet.
        if (sec) begin
          state_n = S_GEN;
          idx_n   = 3'd0;
        end
      end
      S_GEN: begin
        gen   = 1'b1;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (frame_start) begin
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Sample shaping from the current LFSR value. y0 values that would leave
  // less than MIN_SIZE lines below them are folded up by 256 lines.
  always_comb begin
    l9     = lfsr[8:0];
    y_fold = (l9 < 9'(V_ACTIVE - MIN_SIZE)) ? l9 : (l9 - 9'd256);
    size   = 9'(MIN_SIZE) + {2'b00, lfsr[6:0]};
    case (idx[1:0])
      2'd0:    sample = l9;
      2'd1:    sample = y_fold;
      default: sample = size;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 9'd0;
        act[i]    <= 9'd0;
      end
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (gen) shadow[idx] <= sample;
      if (commit) begin
        for (int i = 0; i < 8; i++) act[i] <= shadow[i];
      end
    end
  end

  // Bounds are widened to 11 bits so x0+w / y0+h never wrap back onto the screen.
  function automatic logic contains(input logic [9:0] hc, input logic [9:0] vc,
                                    input logic [8:0] x0, input logic [8:0] y0,
                                    input logic [8:0] w,  input logic [8:0] h);
    logic [10:0] hx, vy, xl, yl, xr, yr;
    hx = {1'b0, hc};
    vy = {1'b0, vc};
    xl = {2'b00, x0};
    yl = {2'b00, y0};
    xr = xl + {2'b00, w};
    yr = yl + {2'b00, h};
    return (hx >= xl) && (hx < xr) && (vy >= yl) && (vy < yr);
  endfunction

  assign in_r = contains(hcnt, vcnt, act[0], act[1], act[2], act[3]);
  assign in_b = contains(hcnt, vcnt, act[4], act[5], act[6], act[7]);

  always_ff @(posedge clk) begin
    if (rst || !video_on) begin
      red   <= 2'd0;
      green <= 2'd0;
      blue  <= 2'd0;
    end else if (in_b) begin
      red   <= 2'd0;
      green <= 2'd0;
      blue  <= 2'd3;
    end else if (in_r) begin
      red   <= 2'd3;
      green <= 2'd0;
      blue  <= 2'd0;
    end else begin
      red   <= 2'd3;
      green <= 2'd3;
      blue  <= 2'd3;
    end
  end

endmodule

// File: tb/tb_rect_painter.sv
// tb/tb_rect_painter.sv - directed self-checking bench for rect_painter
module tb_rect_painter;

  logic       clk = 1'b0;
  logic       rst, sec, frame_start, video_on;
  logic [9:0] hcnt, vcnt;
  logic [1:0] red, green, blue;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] ml;
  int          e [8];
  int          a [8];
  int          d;

  rect_painter dut (
    .clk(clk), .rst(rst), .sec(sec), .frame_start(frame_start),
    .hcnt(hcnt), .vcnt(vcnt), .video_on(video_on),
    .red(red), .green(green), .blue(blue), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    if (rst) ml <= 16'hACE1;
    else     ml <= step(ml);
  end

  function automatic int shape(input logic [15:0] l, input int j);
    int l9;
    l9 = int'(l) & 511;
    if (j % 4 == 0) return l9;
    if (j % 4 == 1) return (l9 < 448) ? l9 : l9 - 256;
    return 32 + (int'(l) & 127);
  endfunction

  function automatic int find_delay(input logic [15:0] l, input int j, input int target);
    logic [15:0] cur;
    cur = l;
    for (int i = 0; i <= j; i++) cur = step(cur);
    for (int t = 0; t < 20000; t++) begin
      if ((int'(cur) & 511) == target) return t;
      cur = step(cur);
    end
    return -1;
  endfunction

  function automatic bit inr(input int h, input int v, input int b);
    return h >= a[b] && h < a[b] + a[b+2] && v >= a[b+1] && v < a[b+1] + a[b+3];
  endfunction

  function automatic logic [5:0] exp_pix(input int h, input int v);
    if (!(h < 640 && v < 480)) return 6'h00;
    if (inr(h, v, 4)) return 6'b000011;
    if (inr(h, v, 0)) return 6'b110000;
    return 6'h3F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pix(input int h, input int v);
    if (h < 0 || h > 1023 || v < 0 || v > 1023) return;
    hcnt     = h[9:0];
    vcnt     = v[9:0];
    video_on = (h < 640 && v < 480);
    tick();
    check($sformatf("pix(%0d,%0d)", h, v), {26'd0, red, green, blue}, {26'd0, exp_pix(h, v)});
  endtask

  // Capture the eight expected shadow values for a sec that is about to be sampled.
  task automatic predict();
    logic [15:0] cur;
    cur = ml;
    for (int j = 0; j < 8; j++) begin
      cur  = step(cur);
      e[j] = shape(cur, j);
    end
  endtask

  task automatic check_edges(input int b);
    int xs [4];
    int ys [4];
    xs = '{a[b] - 1, a[b], a[b] + a[b+2] - 1, a[b] + a[b+2]};
    ys = '{a[b+1] - 1, a[b+1], a[b+1] + a[b+3] - 1, a[b+1] + a[b+3]};
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        check_pix(xs[i], ys[k]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) a[i] = 0;
    rst = 1'b1; sec = 1'b0; frame_start = 1'b0;
    hcnt = 10'd100; vcnt = 10'd100; video_on = 1'b1;

    // Reset state
    tick();
    check("reset_rgb", {26'd0, red, green, blue}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("white_after_reset", {26'd0, red, green, blue}, 32'h3F);
    video_on = 1'b0;
    tick();
    check("blank", {26'd0, red, green, blue}, 32'h00);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Round 1: red y0 sample lands on L[8:0]=460 to exercise the fold
    d = find_delay(ml, 1, 460);
    check("find_fold", {31'd0, d < 0}, 32'd0);
    if (d < 0) d = 0;
    repeat (d) tick();
    predict();
    sec = 1'b1;
    tick();
    sec = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    frame_start = 1'b1; sec = 1'b1;
    tick();
    frame_start = 1'b0; sec = 1'b0;
    check("busy_gen", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    for (int j = 0; j < 8; j++)
      check($sformatf("shadow%0d", j), {23'd0, dut.shadow[j]}, e[j]);
    check("fold_y0", {23'd0, dut.shadow[1]}, 32'd204);
    check_pix(e[0], e[1]);
    sec = 1'b1;
    tick();
    sec = 1'b0;
    check("sec_in_wait", {23'd0, dut.shadow[0]}, e[0]);
    check("busy_wait", {31'd0, busy}, 32'd1);
    repeat (8) tick();
    check("busy_before_commit", {31'd0, busy}, 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_fall", {31'd0, busy}, 32'd0);
    for (int j = 0; j < 8; j++) a[j] = e[j];
    check_edges(0);
    check_edges(4);
    check_pix((a[0] > a[4]) ? a[0] : a[4], (a[1] > a[5]) ? a[1] : a[5]);

    // Round 2: red x0=511, sec coincident with frame_start in IDLE
    d = find_delay(ml, 0, 511);
    check("find_x511", {31'd0, d < 0}, 32'd0);
    if (d < 0) d = 0;
    repeat (d) tick();
    predict();
    sec = 1'b1; frame_start = 1'b1;
    tick();
    sec = 1'b0; frame_start = 1'b0;
    check("busy_sec_fs", {31'd0, busy}, 32'd1);
    check_pix(a[0], a[1]);
    check_pix(a[4], a[5]);
    repeat (8) tick();
    check("busy_wait2", {31'd0, busy}, 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_fall2", {31'd0, busy}, 32'd0);
    for (int j = 0; j < 8; j++) a[j] = e[j];
    check("x0_511", a[0], 32'd511);
    foreach (e[j]) begin end
    check_pix(510, a[1]);
    check_pix(511, a[1]);
    check_pix(511 + a[2] - 1, a[1]);
    check_pix(511 + a[2], a[1]);
    check_pix(639, a[1]);
    check_pix(0, a[1]);
    check_pix(1, a[1]);
    check_edges(4);

    // Round 3: reset while waiting for frame_start
    predict();
    sec = 1'b1;
    tick();
    sec = 1'b0;
    repeat (10) tick();
    check("busy_wait3", {31'd0, busy}, 32'd1);
    rst = 1'b1; video_on = 1'b1; hcnt = 10'd200; vcnt = 10'd200;
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rgb", {26'd0, red, green, blue}, 32'h00);
    frame_start = 1'b1;
    hcnt = 10'(e[0]); vcnt = 10'(e[1]);
    tick();
    frame_start = 1'b0;
    check("no_commit_after_rst", {31'd0, busy}, 32'd0);
    check("act_cleared", {23'd0, dut.act[2]}, 32'd0);
    for (int j = 0; j < 8; j++) a[j] = 0;
    check_pix(e[0], e[1]);
    check_pix(511, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rect_painter.md
# rect_painter

Pixel-colour stage that sits between the VGA timing generator and the RGB pins. On every one-second pulse it draws a new pair of pseudo-random rectangles, one red and one blue, on a white background. New geometry is generated into shadow registers and committed only at a frame boundary, so a frame never tears. Output is 2 bits per colour channel, registered.

## Interface
- LFSR_SEED, 16'hACE1, non-zero reset value of the LFSR.
- MIN_SIZE, 32, minimum rectangle width/height in pixels.
- V_ACTIVE, 480, visible lines; used for y0 fold.
- clk  in  1  pixel clock (25 MHz); single clock domain.
- rst  in  1  synchronous, active-high reset.
- sec  in  1  one-cycle pulse, once per second.
- frame_start  in  1  one-cycle pulse before the first active pixel of each frame.
- hcnt  in  10  current pixel column.
- vcnt  in  10  current line.
- video_on  in  1  high while (hcnt, vcnt) is visible.
- red  out  2  red pixel level.
- green  out  2  green pixel level.
- blue  out  2  blue pixel level.
- busy  out  1  high while new geometry is pending (GEN or WAIT).

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, shift right; steps every clk cycle while not in reset. Reset loads LFSR_SEED.
- FSM states: IDLE, GEN, WAIT.
  - IDLE: on sec=1, go to GEN with idx=0.
  - GEN: one sample per cycle, idx 0..7, into shadow regs in this order: x0_r, y0_r, w_r, h_r, x0_b, y0_b, w_b, h_b. After idx=7, go to WAIT.
  - WAIT: on frame_start=1, copy all eight shadow regs into the active regs in that same cycle, then go to IDLE.
- Sample rules use current LFSR value L:
  - x0 = L[8:0], range 0..511.
  - y0 = L[8:0] if L[8:0] < V_ACTIVE-MIN_SIZE, else L[8:0]-256.
  - w, h = MIN_SIZE + L[6:0], range 32..159.
- Containment: inside when hcnt ≥ x0, hcnt < x0+w, vcnt ≥ y0, vcnt < y0+h. Sums are computed at 11 bits with no wrap. Off-screen parts clip naturally because video_on is low there.
- Pixel colour, priority high to low:
  - !video_on → 0/0/0.
  - inside blue → red=0, green=0, blue=3.
  - inside red → red=3, green=0, blue=0.
  - else white → 3/3/3.
- busy = (state != IDLE).

## Timing
- Reset (synchronous, dominates all inputs):
  - state=IDLE, idx=0, LFSR=LFSR_SEED.
  - shadow and active regs all 0, so width 0 and no rectangle is visible.
  - red=green=blue=0, busy=0.
- Reset asserted mid-GEN or mid-WAIT aborts; pending geometry is discarded.
- Pixel path latency: exactly 1 clk from hcnt/vcnt/video_on to red/green/blue.
- sec sampled at edge k: busy=1 from edge k. GEN occupies cycles k+1..k+8. WAIT starts at edge k+8.
- Commit: active regs change at the edge that samples frame_start in WAIT. They affect pixels from the next cycle on; busy falls at that same edge.
- sec while busy=1 is ignored (no queuing).
- sec and frame_start in the same cycle in IDLE: enter GEN; that frame_start causes no commit.
- frame_start during GEN does not commit; the block waits for the next frame_start in WAIT.
- Minimum sec-to-visible latency is 9 cycles plus the wait for frame_start.

## Test plan
- Reset with video_on=1: outputs 0 on the reset cycle, then 3/3/3 on every visible pixel; video_on=0 gives 0/0/0; busy=0.
- sec pulse at cycle k with no frame_start: busy rises at k and stays high. The eight shadow values match a bit-exact LFSR model (seed 16'hACE1) sampled at k+1..k+8. Active output is still all white.
- frame_start at k+20: one frame scanned by the bench matches the model. Blue overlaps red with blue winning. Rectangle edges are inclusive at x0 and exclusive at x0+w. busy falls at k+20.
- Fold and clip: force L[8:0]=460 at a y0 sample (via seed choice) → y0=204. x0=511 with w=159 → drawn only for hcnt 511..639, no wrap to column 0.
- sec again while busy, and frame_start during GEN: neither restarts nor commits. Only the WAIT-state frame_start commits, then the block returns to IDLE.
- rst asserted in WAIT: busy=0 and outputs 0 next cycle. Active regs cleared, giving a white screen after reset; the later frame_start has no effect.
